// File: rtl/vc_crossbar4_router_pkg.sv
// vc_crossbar4_router_pkg: shared port count, destination width and bus types for the 4x4 router
package vc_crossbar4_router_pkg;
  localparam int NPORTS = 4;
  localparam int DEST_NBITS = 2;
  typedef logic [DEST_NBITS-1:0] port_t;
  typedef logic [NPORTS-1:0] vec_t;
endpackage

// File: rtl/vc_crossbar4_rr_arb.sv
// vc_crossbar4_rr_arb: 4-way round-robin arbiter owning its priority pointer
//   clk, reset   clock, async active-high reset (pointer -> 0)
//   req_i        per-input request
//   en_i         output can load this cycle; no grant when low
//   grant_o      one-hot grant
//   idx_o        granted index, or the current pointer when nothing is granted
//   hit_o        a grant was issued
module vc_crossbar4_rr_arb
  import vc_crossbar4_router_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  vec_t  req_i,
  input  logic  en_i,
  output vec_t  grant_o,
  output port_t idx_o,
  output logic  hit_o
);
  port_t ptr_q, ptr_d, off;
  logic [2*NPORTS-1:0] dbl;
  vec_t rot;
  // Rotate requests so the pointer position sits at bit 0, then take the first set bit.
  always_comb begin
    dbl = {req_i, req_i} >> ptr_q;
    rot = dbl[NPORTS-1:0];
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    hit_o = en_i && |req_i;
    idx_o = hit_o ? ptr_q + off : ptr_q;
    grant_o = hit_o ? vec_t'(1) << idx_o : '0;
    ptr_d = hit_o ? idx_o + 2'd1 : ptr_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/vc_crossbar4_router.sv
// vc_crossbar4_router: val/rdy 4x4 crossbar router with per-output round-robin and one-entry output buffers
//   clk, reset          clock, async active-high reset
//   domain              security domain captured with each accepted message
//   in_val/in_rdy       per-input handshake; in_rdy is combinational from in_val/in_dest/out_rdy
//   in_msg, in_dest     packed payloads (p_nbits each) and 2-bit destinations
//   out_val/out_rdy     per-output handshake on the registered buffers
//   out_msg, out_domain registered payloads and their captured domain
module vc_crossbar4_router
  import vc_crossbar4_router_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         domain,
  input  vec_t                         in_val,
  output vec_t                         in_rdy,
  input  logic [NPORTS*p_nbits-1:0]    in_msg,
  input  logic [NPORTS*DEST_NBITS-1:0] in_dest,
  output vec_t                         out_val,
  input  vec_t                         out_rdy,
  output logic [NPORTS*p_nbits-1:0]    out_msg,
  output vec_t                         out_domain
);
  logic [p_nbits-1:0] in_a [NPORTS];
  logic [p_nbits-1:0] xbar [NPORTS];
  logic [p_nbits-1:0] msg_q [NPORTS];
  logic [p_nbits-1:0] msg_d [NPORTS];
  vec_t req [NPORTS];
  vec_t gnt [NPORTS];
  port_t sel [NPORTS];
  vec_t hit, can_load, val_q, val_d, dom_q, dom_d;
  always_comb begin
    in_rdy = '0;
    for (int j = 0; j < NPORTS; j++) begin
      in_a[j] = in_msg[j*p_nbits +: p_nbits];
      can_load[j] = !val_q[j] || out_rdy[j];
      for (int i = 0; i < NPORTS; i++)
        req[j][i] = in_val[i] && in_dest[i*DEST_NBITS +: DEST_NBITS] == port_t'(j);
    end
    for (int j = 0; j < NPORTS; j++) begin
      xbar[j] = in_a[sel[j]];
      in_rdy = in_rdy | gnt[j];
      val_d[j] = hit[j] || (val_q[j] && !out_rdy[j]);
      dom_d[j] = hit[j] ? domain : dom_q[j];
      msg_d[j] = hit[j] ? xbar[j] : msg_q[j];
    end
  end
  // Arbiters are disabled during reset so in_rdy stays low while it is asserted.
  for (genvar j = 0; j < NPORTS; j++) begin : g_out
    vc_crossbar4_rr_arb u_arb (
      .clk     (clk),
      .reset   (reset),
      .req_i   (req[j]),
      .en_i    (can_load[j] && !reset),
      .grant_o (gnt[j]),
      .idx_o   (sel[j]),
      .hit_o   (hit[j])
    );
    assign out_msg[j*p_nbits +: p_nbits] = msg_q[j];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      val_q <= '0;
      dom_q <= '0;
      for (int j = 0; j < NPORTS; j++) msg_q[j] <= '0;
    end else begin
      val_q <= val_d;
      dom_q <= dom_d;
      msg_q <= msg_d;
    end
  assign out_val = val_q;
  assign out_domain = dom_q;
endmodule

// File: tb/tb_vc_crossbar4_router.sv
// tb_vc_crossbar4_router: directed + random scoreboard bench for vc_crossbar4_router
module tb_vc_crossbar4_router;
  typedef struct {
    int          port;
    logic [31:0] msg;
    logic        dom;
  } sb_t;
  logic clk = 0, reset = 1, domain = 0;
  logic [3:0] in_val = 0, in_rdy, out_val, out_rdy = 0, out_domain;
  logic [127:0] in_msg = 0, out_msg;
  logic [7:0] in_dest = 0;
  int n_vec = 0, n_err = 0;
  int mptr [4];
  bit mval [4];
  sb_t sb [$];
  always #5 clk = ~clk;
  vc_crossbar4_router #(.p_nbits(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .domain     (domain),
    .in_val     (in_val),
    .in_rdy     (in_rdy),
    .in_msg     (in_msg),
    .in_dest    (in_dest),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .out_msg    (out_msg),
    .out_domain (out_domain)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int j = 0; j < 4; j++) begin
      mptr[j] = 0;
      mval[j] = 0;
    end
    sb.delete();
  endtask
  // Called just after a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    logic [3:0] exp_rdy, mv;
    bit found;
    int i;
    sb_t e;
    #1;
    exp_rdy = 0;
    for (int j = 0; j < 4; j++) begin
      if (!mval[j] || out_rdy[j]) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          i = (mptr[j] + k) % 4;
          if (!found && in_val[i] && in_dest[2*i +: 2] == 2'(j)) begin
            found = 1;
            exp_rdy[i] = 1;
            sb.push_back('{j, in_msg[i*32 +: 32], domain});
            mptr[j] = (i + 1) % 4;
            mval[j] = 1;
          end
        end
        if (!found && out_rdy[j]) mval[j] = 0;
      end
    end
    chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("out_msg%0d", e.port), out_msg[e.port*32 +: 32], e.msg);
      chk($sformatf("out_domain%0d", e.port), 32'(out_domain[e.port]), 32'(e.dom));
    end
    for (int j = 0; j < 4; j++) mv[j] = mval[j];
    chk("out_val", 32'(out_val), 32'(mv));
    @(negedge clk);
  endtask
  initial begin
    in_val = 4'hF;
    in_dest = 8'b11_10_01_00;
    out_rdy = 4'hF;
    in_msg = {$urandom, $urandom, $urandom, $urandom};
    #2;
    chk("rst_in_rdy", 32'(in_rdy), 32'h0);
    chk("rst_out_val", 32'(out_val), 32'h0);
    chk("rst_out_domain", 32'(out_domain), 32'h0);
    chk("rst_out_msg", out_msg[31:0] | out_msg[63:32] | out_msg[95:64] | out_msg[127:96], 32'h0);
    @(negedge clk);
    reset = 0;
    model_reset();
    repeat (3) begin
      in_msg = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_val = 0;
    out_rdy = 0;
    step();
    in_val = 4'hF;
    out_rdy = 4'hF;
    #1 reset = 1;
    #1;
    chk("midrst_out_val", 32'(out_val), 32'h0);
    chk("midrst_in_rdy", 32'(in_rdy), 32'h0);
    chk("midrst_out_msg", out_msg[31:0] | out_msg[63:32] | out_msg[95:64] | out_msg[127:96], 32'h0);
    in_val = 0;
    reset = 0;
    model_reset();
    @(negedge clk);
    in_dest = 8'b10_10_10_10;
    in_val = 4'hF;
    out_rdy = 4'b0100;
    in_msg = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0000};
    repeat (5) step();
    in_val = 0;
    out_rdy = 4'hF;
    step();
    out_rdy = 4'b1101;
    in_val = 4'b0001;
    in_dest = 8'b00_00_00_01;
    step();
    in_val = 4'b1000;
    in_dest = 8'b01_00_00_00;
    in_msg[96 +: 32] = 32'hCAFE_0003;
    step();
    step();
    out_rdy = 4'hF;
    step();
    in_val = 0;
    step();
    domain = 1;
    in_val = 4'b0100;
    in_dest = 8'b00_00_00_00;
    in_msg[64 +: 32] = 32'hDEAD_BEEF;
    step();
    domain = 0;
    in_val = 0;
    step();
    repeat (60) begin
      in_val = 4'($urandom);
      in_dest = 8'($urandom);
      out_rdy = 4'($urandom);
      domain = 1'($urandom);
      in_msg = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
